// File: rtl/seq_mult_pkg.sv
// Shared encodings and widths for the sequential 8x8 multiplier controller.
// The controller builds the product from four 4x4 nibble products.
package seq_mult_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 8;
    localparam int RES_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_LSB       = 3'd2,
        S_MID       = 3'd3,
        S_MSB       = 3'd4,
        S_CALC_DONE = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEL_ALO_BLO = 2'b00,
        SEL_ALO_BHI = 2'b01,
        SEL_AHI_BLO = 2'b10,
        SEL_AHI_BHI = 2'b11
    } in_sel_t;

    typedef enum logic [1:0] {
        SHIFT_0 = 2'b00,
        SHIFT_4 = 2'b01,
        SHIFT_8 = 2'b10
    } shift_t;

    // A step is legal when the counter value matches what the state expects.
    function automatic logic step_legal(input state_t s, input logic [1:0] c);
        case (s)
            S_LSB:   return c == 2'd0;
            S_MID:   return (c == 2'd1) || (c == 2'd2);
            S_MSB:   return c == 2'd3;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_acc.sv
// Shift-and-accumulate datapath: adds the shifted nibble product into a
// 16-bit accumulator; clr (or reset) zeroes it.
module shift_acc
    import seq_mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod_in,
    input  logic [1:0]        shift_sel,
    input  logic              en,
    input  logic              clr,
    output logic [RES_W-1:0]  acc
);

    logic [RES_W-1:0] addend;

    always_comb begin
        // NOTE: every path assigns addend, so no latch is inferred.
        addend = RES_W'(prod_in);
        case (shift_sel)
            SHIFT_4: addend = RES_W'(prod_in) << 4;
            SHIFT_8: addend = RES_W'(prod_in) << 8;
            default: addend = RES_W'(prod_in);
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing FSM for an 8x8 multiply built from four nibble products, driving
// an external 2-bit step counter and the shift_acc datapath.
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        count,
    input  logic [PROD_W-1:0] prod_in,
    output logic [1:0]        input_sel,
    output logic [1:0]        shift_sel,
    output logic              clk_ena,
    output logic              sclr_n,
    output logic [2:0]        state_out,
    output logic              done,
    output logic              err,
    output logic [RES_W-1:0]  product
);

    state_t state;
    state_t state_nx;
    logic   step_state;
    logic   acc_en;
    logic   acc_clr;

    assign step_state = state inside {S_LSB, S_MID, S_MSB};
    assign acc_en     = step_legal(state, count);
    assign acc_clr    = (state == S_CLEAR);
    assign state_out  = state;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CLEAR;
            S_CLEAR: state_nx = S_LSB;
            S_LSB:   state_nx = (count == 2'd0) ? S_MID : S_ERR;
            S_MID: begin
                if (count == 2'd1)      state_nx = S_MID;
                else if (count == 2'd2) state_nx = S_MSB;
                else                    state_nx = S_ERR;
            end
            S_MSB:   state_nx = (count == 2'd3) ? S_CALC_DONE : S_ERR;
            // Held start parks here so one request never retriggers.
            S_CALC_DONE, S_ERR: if (!start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Select decode follows the live counter so prod_in matches this step.
    always_comb begin
        input_sel = SEL_ALO_BLO;
        shift_sel = SHIFT_0;
        if (step_state) begin
            case (count)
                2'd1: begin input_sel = SEL_ALO_BHI; shift_sel = SHIFT_4; end
                2'd2: begin input_sel = SEL_AHI_BLO; shift_sel = SHIFT_4; end
                2'd3: begin input_sel = SEL_AHI_BHI; shift_sel = SHIFT_8; end
                default: begin input_sel = SEL_ALO_BLO; shift_sel = SHIFT_0; end
            endcase
        end
    end

    // Moore outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
            clk_ena <= 1'b0;
            sclr_n  <= 1'b1;
        end else begin
            state   <= state_nx;
            done    <= (state_nx == S_CALC_DONE);
            err     <= (state_nx == S_ERR);
            clk_ena <= state_nx inside {S_LSB, S_MID, S_MSB};
            sclr_n  <= (state_nx != S_CLEAR);
        end
    end

    shift_acc u_shift_acc (
        .clk       (clk),
        .reset     (reset),
        .prod_in   (prod_in),
        .shift_sel (shift_sel),
        .en        (acc_en),
        .clr       (acc_clr),
        .acc       (product)
    );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl with a modelled step counter and 4x4
// nibble multiplier; expected products come from plain a*b.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  count;
    logic [7:0]  prod_in;
    logic [1:0]  input_sel;
    logic [1:0]  shift_sel;
    logic        clk_ena;
    logic        sclr_n;
    logic [2:0]  state_out;
    logic        done;
    logic        err;
    logic [15:0] product;

    seq_mult_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .prod_in   (prod_in),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n),
        .state_out (state_out),
        .done      (done),
        .err       (err),
        .product   (product)
    );

    always #5 clk = ~clk;

    // Upstream counter: async clear on sclr_n, advance on clk_ena.
    logic [1:0] cnt_q = 2'd0;
    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'd0;
    always @(posedge clk or negedge sclr_n) begin
        if (!sclr_n)      cnt_q <= 2'd0;
        else if (clk_ena) cnt_q <= cnt_q + 2'd1;
    end
    assign count = force_en ? force_val : cnt_q;

    // 4x4 multiplier on the selected operand nibbles.
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    always_comb begin
        logic [3:0] na;
        logic [3:0] nb;
        na = input_sel[1] ? op_a[7:4] : op_a[3:0];
        nb = input_sel[0] ? op_b[7:4] : op_b[3:0];
        prod_in = {4'b0, na} * {4'b0, nb};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] exp_prod;
        int          issue_cyc;
    } txn_t;
    txn_t sb_q[$];

    // Monitor: each rising done pops one expected result.
    logic done_d = 1'b0;
    txn_t mon_t;
    always @(negedge clk) begin
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("done_without_request", sb_q.size(), 1);
            end else begin
                mon_t = sb_q.pop_front();
                check("product_at_done", product, mon_t.exp_prod);
                check("done_latency", cyc - mon_t.issue_cyc, 6);
            end
        end
        done_d <= done;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (state_out !== 3'd0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, state_out, 3'd0);
    endtask

    // One multiply; hold keeps start high for extra cycles after done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        txn_t        t;
        logic [20:0] tr;
        logic [15:0] e;
        wait_idle("idle_before_op");
        op_a  = a;
        op_b  = b;
        e     = {8'b0, a} * {8'b0, b};
        start = 1'b1;
        t.exp_prod  = e;
        t.issue_cyc = cyc;
        sb_q.push_back(t);
        tr = {18'b0, state_out};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tr = {tr[17:0], state_out};
        end
        check("state_trace", tr, {3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5});
        check("done_high", done, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_state", state_out, 3'd5);
            check("hold_product", product, e);
            check("hold_no_clear", sclr_n, 1'b1);
        end
        start = 1'b0;
        @(negedge clk);
        check("back_to_idle", state_out, 3'd0);
        check("done_low_idle", done, 1'b0);
        check("product_held_idle", product, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state_out, 3'd0);
        check("rst_product", product, 16'h0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_clk_ena", clk_ena, 1'b0);
        check("rst_sclr_n", sclr_n, 1'b1);
        check("rst_selects", {input_sel, shift_sel}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);

        // Full-scale operands, then a small pair to show CLEAR zeroes acc.
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h12, 8'h34, 1);
        run_op(8'h00, 8'hA5, 0);
        run_op(8'h0F, 8'hF0, 0);

        // Illegal count in LSB aborts to ERR with acc still cleared.
        wait_idle("idle_before_err");
        op_a  = 8'h9C;
        op_b  = 8'h47;
        start = 1'b1;
        @(negedge clk);
        check("err_clear_state", state_out, 3'd1);
        check("err_clear_sclr_n", sclr_n, 1'b0);
        @(negedge clk);
        check("err_lsb_state", state_out, 3'd2);
        force_en  = 1'b1;
        force_val = 2'd2;
        #1;
        check("forced_selects", {input_sel, shift_sel}, 4'b1001);
        @(negedge clk);
        force_en = 1'b0;
        check("err_state", state_out, 3'd6);
        check("err_flag", err, 1'b1);
        check("err_product", product, 16'h0);
        check("err_clk_ena", clk_ena, 1'b0);
        check("err_selects", {input_sel, shift_sel}, 4'b0000);
        @(negedge clk);
        check("err_held_start", state_out, 3'd6);
        start = 1'b0;
        @(negedge clk);
        check("err_exit_idle", state_out, 3'd0);
        check("err_flag_low", err, 1'b0);

        // Reset during the second MID cycle aborts the multiply.
        op_a  = 8'hC3;
        op_b  = 8'h5A;
        start = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_mid2_state", state_out, 3'd3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", state_out, 3'd0);
        check("abort_product", product, 16'h0);
        check("abort_done", done, 1'b0);
        check("abort_clk_ena", clk_ena, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_idle", state_out, 3'd0);

        // Long held start after done must not restart.
        run_op(8'hB7, 8'h6D, 10);

        // Reset and start together: reset wins, CLEAR never entered.
        reset = 1'b1;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_start_state", state_out, 3'd0);
            check("rst_start_sclr_n", sclr_n, 1'b1);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_release", state_out, 3'd0);

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
